// File: rtl/ext_sram_pkg.sv
// Shared definitions for the external asynchronous SRAM controller:
// state encoding, half-word phase constants and default chip timing.
package ext_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic PH_LO = 1'b0;
    localparam logic PH_HI = 1'b1;

    localparam int DEF_SRAM_AW     = 18;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/ext_sram_ctl.sv
// Serves 32-bit core requests as two 16-bit accesses (low half, then high half)
// to an external async SRAM. Optional macro EXT_SRAM_FASTREAD_EN drops the mid-read GAP.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for valid; request fields latched on acceptance
// ACC   | chip strobed for WAIT_CYCLES cycles on the current half-word
// GAP   | strobe released, address and write data held for one cycle
// RESP  | one-cycle ready pulse back to the requester
module ext_sram_ctl
    import ext_sram_pkg::*;
#(
    parameter int SRAM_AW     = DEF_SRAM_AW,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    output logic               ready,
    input  logic [31:0]        addr,
    input  logic [31:0]        dtw,
    output logic [31:0]        dtr,
    input  logic               rw,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_t             r_state;
    logic               r_phase;
    logic [CW-1:0]      r_cnt;
    logic [SRAM_AW-2:0] r_addr;
    logic [31:0]        r_dtw;
    logic               r_rw;
    logic               r_ready;
    logic [31:0]        r_dtr;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_dq_oe;

    state_t             w_state_nxt;
    logic               w_phase_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_accept;
    logic               w_capture;
    logic               w_rw_nxt;
    logic               w_acc_nxt;
    logic               w_act_nxt;
    logic [33-SRAM_AW:0] w_unused_addr;

    // Only the chip-sized word index is kept, so larger addresses alias.
    assign w_unused_addr = {addr[31:SRAM_AW+1], addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_accept    = 1'b1;
                    w_phase_nxt = PH_LO;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ACC;
                end
            end
            ACC: begin
                if (r_cnt == CNT_LAST) begin
                    w_capture = ~r_rw;
                    w_cnt_nxt = '0;
`ifdef EXT_SRAM_FASTREAD_EN
                    if (!r_rw && (r_phase == PH_LO)) begin
                        w_phase_nxt = PH_HI;
                    end else begin
                        w_state_nxt = GAP;
                    end
`else
                    w_state_nxt = GAP;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            GAP: begin
                if (r_phase == PH_LO) begin
                    w_phase_nxt = PH_HI;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ACC;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so the pins never glitch.
    assign w_rw_nxt  = w_accept ? rw : r_rw;
    assign w_acc_nxt = (w_state_nxt == ACC);
    assign w_act_nxt = (w_state_nxt == ACC) || (w_state_nxt == GAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_phase <= PH_LO;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_dtw   <= '0;
            r_rw    <= 1'b0;
            r_ready <= 1'b0;
            r_dtr   <= '0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr <= addr[SRAM_AW:2];
                r_dtw  <= dtw;
                r_rw   <= rw;
            end
            if (w_capture) begin
                if (r_phase == PH_HI) begin
                    r_dtr[31:16] <= sram_dq_in;
                end else begin
                    r_dtr[15:0] <= sram_dq_in;
                end
            end
            r_ready <= (w_state_nxt == RESP);
            r_ce_n  <= ~w_act_nxt;
            r_oe_n  <= ~(w_acc_nxt & ~w_rw_nxt);
            r_we_n  <= ~(w_acc_nxt & w_rw_nxt);
            r_dq_oe <= w_act_nxt & w_rw_nxt;
        end
    end

    assign ready       = r_ready;
    assign dtr         = r_dtr;
    assign sram_addr   = {r_addr, r_phase};
    assign sram_dq_out = (r_phase == PH_HI) ? r_dtw[31:16] : r_dtw[15:0];
    assign sram_dq_oe  = r_dq_oe;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;

endmodule
